sccb_responder: RTL and testbench

- SCCB (I2C-compatible) target that answers the camera-configuration master and receives the same register traffic the OV7725 sees: device ID 0x42 write / 0x43 read, sub-address, data.
- Used as a synthesizable camera stand-in for bring-up and self-test. Also used as a bus monitor that reports every register write.
- Oversamples SCL/SDA on the system clock and drives SDA open-drain via an output-enable.
- Holds a 256x8 register file.

---
 rtl/sccb_pkg.sv | 23 ++
 rtl/sccb_line_filter.sv | 46 ++++
 rtl/sccb_responder.sv | 210 +++++++++++++++++++++
 tb/tb_sccb_responder.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sccb_pkg.sv
// Shared types and constants for the SCCB responder and its input filters.
package sccb_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ID,
    ID_ACK,
    SUB,
    SUB_ACK,
    WDATA,
    WDATA_ACK,
    RDATA,
    RDATA_ACK,
    WAIT_STOP
  } state_t;

  localparam logic [7:0] OV7725_ID_W = 8'h42;
  localparam logic [7:0] OV7725_ID_R = 8'h43;

  // Deglitch counter width; holds stability windows up to 15 cycles.
  localparam int DG_W = 4;

endpackage

// File: rtl/sccb_line_filter.sv
// Synchronizes one asynchronous bus line, rejects pulses shorter than DEGLITCH
// cycles and flags rising/falling edges of the filtered level.
module sccb_line_filter
  import sccb_pkg::*;
#(
  parameter int DEGLITCH = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic line,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [1:0]      sync;
  logic [DG_W-1:0] cnt;
  logic            level_d;

  // Idle bus level is high, so the filter comes out of reset released.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync    <= 2'b11;
      cnt     <= '0;
      level   <= 1'b1;
      level_d <= 1'b1;
    end else begin
      sync    <= {sync[0], line};
      level_d <= level;
      if (sync[1] != level) begin
        if (cnt == DG_W'(DEGLITCH - 1)) begin
          level <= sync[1];
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

  assign rise = level & ~level_d;
  assign fall = ~level & level_d;

endmodule

// File: rtl/sccb_responder.sv
// SCCB target: answers the camera-configuration master from a 256x8 register
// file and reports every accepted register write as a one-cycle pulse.
module sccb_responder
  import sccb_pkg::*;
#(
  parameter logic [7:0] SLAVE_ADDR = OV7725_ID_W,
  parameter int         DEGLITCH   = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic       wr_valid,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       busy
);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;

  sccb_line_filter #(.DEGLITCH(DEGLITCH)) u_scl_filt (
    .clk   (clk),
    .rst   (rst),
    .line  (scl_i),
    .level (scl_lvl),
    .rise  (scl_rise),
    .fall  (scl_fall)
  );

  sccb_line_filter #(.DEGLITCH(DEGLITCH)) u_sda_filt (
    .clk   (clk),
    .rst   (rst),
    .line  (sda_i),
    .level (sda_lvl),
    .rise  (sda_rise),
    .fall  (sda_fall)
  );

  logic start, stop;
  assign start = sda_fall & scl_lvl;
  assign stop  = sda_rise & scl_lvl;

  state_t     state, state_n;
  logic [3:0] bit_cnt, bit_cnt_n;
  logic [7:0] shift, shift_n;
  logic [7:0] tx, tx_n;
  logic [7:0] ptr, ptr_n;
  logic       ack_on, ack_on_n;
  logic       is_read, is_read_n;
  logic       sda_oe_n, wr_valid_n, busy_n;
  logic [7:0] wr_addr_n, wr_data_n;
  logic       rf_we;
  logic [7:0] rx_byte;
  logic [7:0] rf [256];

  assign rx_byte = {shift[6:0], sda_lvl};

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      shift    <= '0;
      tx       <= '0;
      ptr      <= '0;
      ack_on   <= 1'b0;
      is_read  <= 1'b0;
      sda_oe   <= 1'b0;
      wr_valid <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      busy     <= 1'b0;
    end else begin
      state    <= state_n;
      bit_cnt  <= bit_cnt_n;
      shift    <= shift_n;
      tx       <= tx_n;
      ptr      <= ptr_n;
      ack_on   <= ack_on_n;
      is_read  <= is_read_n;
      sda_oe   <= sda_oe_n;
      wr_valid <= wr_valid_n;
      wr_addr  <= wr_addr_n;
      wr_data  <= wr_data_n;
      busy     <= busy_n;
    end
  end

  // Register file is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (!rst && rf_we) rf[ptr] <= rx_byte;
  end

  always_comb begin
    state_n    = state;
    bit_cnt_n  = bit_cnt;
    shift_n    = shift;
    tx_n       = tx;
    ptr_n      = ptr;
    ack_on_n   = ack_on;
    is_read_n  = is_read;
    sda_oe_n   = sda_oe;
    wr_valid_n = 1'b0;
    wr_addr_n  = wr_addr;
    wr_data_n  = wr_data;
    busy_n     = busy;
    rf_we      = 1'b0;

    if (start) begin
      state_n   = ID;
      bit_cnt_n = '0;
      sda_oe_n  = 1'b0;
      ack_on_n  = 1'b0;
      busy_n    = 1'b1;
    end else if (stop) begin
      state_n   = IDLE;
      bit_cnt_n = '0;
      sda_oe_n  = 1'b0;
      ack_on_n  = 1'b0;
      busy_n    = 1'b0;
    end else begin
      case (state)
        ID, SUB, WDATA: begin
          if (scl_rise) begin
            shift_n   = rx_byte;
            bit_cnt_n = bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              bit_cnt_n = '0;
              if (state == ID) begin
                if (rx_byte == SLAVE_ADDR) begin
                  state_n   = ID_ACK;
                  is_read_n = 1'b0;
                end else if (rx_byte == (SLAVE_ADDR | 8'h01)) begin
                  state_n   = ID_ACK;
                  is_read_n = 1'b1;
                end else begin
                  state_n = WAIT_STOP;
                end
              end else if (state == SUB) begin
                ptr_n   = rx_byte;
                state_n = SUB_ACK;
              end else begin
                rf_we      = 1'b1;
                wr_valid_n = 1'b1;
                wr_addr_n  = ptr;
                wr_data_n  = rx_byte;
                ptr_n      = ptr + 8'd1;
                state_n    = WDATA_ACK;
              end
            end
          end
        end

        // First falling edge pulls SDA low, the second one ends the ACK slot.
        ID_ACK, SUB_ACK, WDATA_ACK: begin
          if (scl_fall) begin
            if (!ack_on) begin
              sda_oe_n = 1'b1;
              ack_on_n = 1'b1;
            end else begin
              sda_oe_n  = 1'b0;
              ack_on_n  = 1'b0;
              bit_cnt_n = '0;
              if (state == ID_ACK && is_read) begin
                state_n  = RDATA;
                tx_n     = rf[ptr];
                sda_oe_n = ~rf[ptr][7];
              end else if (state == ID_ACK) begin
                state_n = SUB;
              end else begin
                state_n = WDATA;
              end
            end
          end
        end

        RDATA: begin
          if (scl_rise) begin
            bit_cnt_n = bit_cnt + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt == 4'd8) begin
              sda_oe_n  = 1'b0;
              bit_cnt_n = '0;
              state_n   = RDATA_ACK;
            end else begin
              sda_oe_n = ~tx[~bit_cnt[2:0]];
            end
          end
        end

        RDATA_ACK: begin
          if (scl_rise) begin
            if (!sda_lvl) begin
              ptr_n     = ptr + 8'd1;
              tx_n      = rf[ptr + 8'd1];
              bit_cnt_n = '0;
              state_n   = RDATA;
            end else begin
              state_n = WAIT_STOP;
            end
          end
        end

        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sccb_responder.sv
// Bit-banged SCCB master driving the responder; writes are scoreboarded.
module tb_sccb_responder;

  localparam int H = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       scl_m, sda_m;
  logic       sda_line;
  logic       sda_oe, wr_valid, busy;
  logic [7:0] wr_addr, wr_data;

  int n_chk  = 0;
  int n_pass = 0;
  int oe_cnt = 0;
  logic [15:0] exp_q[$];

  assign sda_line = sda_m & ~sda_oe;

  sccb_responder #(.SLAVE_ADDR(8'h42), .DEGLITCH(3)) dut (
    .clk      (clk),
    .rst      (rst),
    .scl_i    (scl_m),
    .sda_i    (sda_line),
    .sda_oe   (sda_oe),
    .wr_valid (wr_valid),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  always @(negedge clk) begin
    if (sda_oe) oe_cnt++;
    if (!rst && wr_valid) begin
      if (exp_q.size() == 0) chk_val("wr_queue_nonempty", exp_q.size(), 1);
      else chk_val("wr_event", {wr_addr, wr_data}, exp_q.pop_front());
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One SCL period; g>0 inserts an SCL-high glitch of g cycles while SCL is low.
  task automatic bus_bit(input logic b, input int g, output logic seen, output logic oe);
    sda_m = b;
    if (g > 0) begin
      wait_cyc(H / 2);
      scl_m = 1'b1;
      wait_cyc(g);
      scl_m = 1'b0;
      wait_cyc(H / 2);
    end else begin
      wait_cyc(H);
    end
    scl_m = 1'b1;
    wait_cyc(H / 2);
    seen = sda_line;
    oe   = sda_oe;
    wait_cyc(H / 2);
    scl_m = 1'b0;
    wait_cyc(4);
  endtask

  task automatic bus_start();
    sda_m = 1'b1;
    wait_cyc(H);
    scl_m = 1'b1;
    wait_cyc(H);
    sda_m = 1'b0;
    wait_cyc(H);
    scl_m = 1'b0;
    wait_cyc(4);
  endtask

  task automatic bus_stop();
    sda_m = 1'b0;
    wait_cyc(H);
    scl_m = 1'b1;
    wait_cyc(H);
    sda_m = 1'b1;
    wait_cyc(H);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gbit, input int glen, output logic ack);
    logic s, o;
    for (int i = 0; i < 8; i++) bus_bit(b[7-i], (i == gbit) ? glen : 0, s, o);
    bus_bit(1'b1, 0, ack, o);
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] d, output logic oe9);
    logic s, o;
    for (int i = 0; i < 8; i++) begin
      bus_bit(1'b1, 0, s, o);
      d[7-i] = s;
    end
    bus_bit(mack, 0, s, oe9);
  endtask

  // Byte seen by the target when bit k (from MSB) is sampled twice.
  function automatic logic [7:0] glitch_byte(input logic [7:0] b, input int k);
    logic [7:0] r;
    for (int j = 0; j < 8; j++) r[7-j] = (j <= k) ? b[7-j] : b[8-j];
    return r;
  endfunction

  initial begin
    logic       a, s, o;
    logic [7:0] d;

    rst   = 1'b1;
    scl_m = 1'b1;
    sda_m = 1'b1;
    wait_cyc(5);
    chk_val("rst_sda_oe", sda_oe, 0);
    chk_val("rst_wr_valid", wr_valid, 0);
    chk_val("rst_wr_addr", wr_addr, 0);
    chk_val("rst_wr_data", wr_data, 0);
    chk_val("rst_busy", busy, 0);
    rst = 1'b0;
    wait_cyc(20);

    // 3-phase write
    bus_start();
    chk_val("busy_at_start", busy, 1);
    send_byte(8'h42, -1, 0, a); chk_val("ack_id_w", a, 0);
    send_byte(8'h12, -1, 0, a); chk_val("ack_sub", a, 0);
    exp_q.push_back(16'h1280);
    send_byte(8'h80, -1, 0, a); chk_val("ack_data", a, 0);
    bus_stop();
    chk_val("busy_after_stop", busy, 0);

    // foreign ID: no ACK, no write
    oe_cnt = 0;
    bus_start();
    send_byte(8'h40, -1, 0, a); chk_val("nack_foreign_id", a, 1);
    send_byte(8'h11, -1, 0, a); chk_val("nack_ignored_sub", a, 1);
    send_byte(8'h00, -1, 0, a);
    chk_val("busy_wait_stop", busy, 1);
    bus_stop();
    chk_val("foreign_oe_count", oe_cnt, 0);
    chk_val("foreign_busy_end", busy, 0);

    // write 0x0C=0xD0, set pointer, read it back with NACK
    bus_start();
    send_byte(8'h42, -1, 0, a);
    send_byte(8'h0C, -1, 0, a);
    exp_q.push_back(16'h0CD0);
    send_byte(8'hD0, -1, 0, a);
    bus_stop();
    bus_start();
    send_byte(8'h42, -1, 0, a);
    send_byte(8'h0C, -1, 0, a);
    bus_stop();
    bus_start();
    send_byte(8'h43, -1, 0, a); chk_val("ack_id_r", a, 0);
    read_byte(1'b1, d, o);
    chk_val("read_0c", d, 8'hD0);
    chk_val("read_released_9th", o, 0);
    bus_stop();
    chk_val("read_busy_end", busy, 0);

    // burst with pointer wrap, then repeated-start read across the wrap
    bus_start();
    send_byte(8'h42, -1, 0, a);
    send_byte(8'hFF, -1, 0, a);
    exp_q.push_back(16'hFF11);
    send_byte(8'h11, -1, 0, a);
    exp_q.push_back(16'h0022);
    send_byte(8'h22, -1, 0, a); chk_val("ack_burst_wrap", a, 0);
    bus_stop();
    bus_start();
    send_byte(8'h42, -1, 0, a);
    send_byte(8'hFF, -1, 0, a);
    bus_start();
    send_byte(8'h43, -1, 0, a);
    read_byte(1'b0, d, o); chk_val("read_ff", d, 8'h11);
    read_byte(1'b1, d, o); chk_val("read_wrap_00", d, 8'h22);
    bus_stop();

    // STOP after 4 data bits: partial byte discarded
    bus_start();
    send_byte(8'h42, -1, 0, a);
    send_byte(8'h10, -1, 0, a);
    for (int i = 0; i < 4; i++) bus_bit(1'b1, 0, s, o);
    bus_stop();
    chk_val("partial_sda_oe", sda_oe, 0);
    chk_val("partial_busy", busy, 0);

    // reset during ACK low
    bus_start();
    for (int i = 0; i < 8; i++) bus_bit(((8'h42 >> (7 - i)) & 8'h01) != 0, 0, s, o);
    sda_m = 1'b1;
    wait_cyc(H);
    scl_m = 1'b1;
    wait_cyc(H / 2);
    chk_val("ack_before_rst", sda_oe, 1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk_val("rst_mid_sda_oe", sda_oe, 0);
    chk_val("rst_mid_busy", busy, 0);
    chk_val("rst_mid_wr_valid", wr_valid, 0);
    rst = 1'b0;
    wait_cyc(H / 2);
    scl_m = 1'b0;
    wait_cyc(H);
    bus_stop();

    // read with pointer from reset (0), sees burst write to 0x00
    bus_start();
    send_byte(8'h43, -1, 0, a); chk_val("ack_id_r_after_rst", a, 0);
    read_byte(1'b1, d, o); chk_val("read_ptr_reset", d, 8'h22);
    bus_stop();

    // SCL glitches: DEGLITCH-1 ignored, DEGLITCH+1 becomes an extra bit
    bus_start();
    send_byte(8'h42, -1, 0, a);
    send_byte(8'h30, -1, 0, a);
    exp_q.push_back(16'h30A5);
    send_byte(8'hA5, 3, 2, a); chk_val("ack_short_glitch", a, 0);
    bus_stop();
    bus_start();
    send_byte(8'h42, -1, 0, a);
    send_byte(8'h31, -1, 0, a);
    exp_q.push_back({8'h31, glitch_byte(8'hA5, 3)});
    send_byte(8'hA5, 3, 4, a);
    bus_stop();
    bus_start();
    send_byte(8'h42, -1, 0, a);
    send_byte(8'h30, -1, 0, a);
    bus_start();
    send_byte(8'h43, -1, 0, a);
    read_byte(1'b0, d, o); chk_val("read_short_glitch", d, 8'hA5);
    read_byte(1'b1, d, o); chk_val("read_long_glitch", d, glitch_byte(8'hA5, 3));
    bus_stop();

    wait_cyc(10);
    chk_val("sb_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
